// File: rtl/comb_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// comb_sweep_ctrl_pkg
// Shared definitions for the truth-table sweep controller.
//   CNT_W     : width of the settle counter
//   LAST_CODE : final input code of a sweep
//   state_t   : FSM state encoding (IDLE, WAIT, SAMPLE, FIN)
// -----------------------------------------------------------------------------
package comb_sweep_ctrl_pkg;

   localparam int         CNT_W     = 4;
   localparam logic [3:0] LAST_CODE = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_SAMPLE = 2'd2,
      S_FIN    = 2'd3
   } state_t;

endpackage

// File: rtl/comb_sweep_ctrl_timer.sv
// -----------------------------------------------------------------------------
// comb_sweep_ctrl_timer
// Settle counter for the sweep controller. Counts enabled cycles since the
// last clear and flags the terminal count (count == SETTLE-1).
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   clr_i   : synchronous clear to zero (wins over enable)
//   en_i    : count enable
//   tc_o    : terminal count reached
// -----------------------------------------------------------------------------
module comb_sweep_ctrl_timer
   import comb_sweep_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   // With SETTLE=0 the controller never enters WAIT, so the value is moot.
   localparam logic [CNT_W-1:0] TC_VAL = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/comb_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// comb_sweep_ctrl
// Drives a 4-input combinational block through codes 0..15, samples its
// output after a settle time, builds the 16-entry truth table and compares
// it with EXPECT.
// Parameters:
//   SETTLE : wait cycles after each new code before Y is sampled (0..15)
//   EXPECT : expected truth table, bit i = Y for code i
// Ports:
//   CLK    : clock
//   RST_N  : asynchronous active-low reset
//   START  : sweep request, honoured only in IDLE
//   ABORT  : cancel an in-progress sweep (WAIT/SAMPLE only)
//   Y      : output of the block under exercise
//   ABCD   : {A,B,C,D} drive of the block under exercise, A is the MSB
//   BUSY   : sweep in progress
//   DONE   : one-cycle completion pulse
//   TT     : captured truth table
//   PASS   : TT == EXPECT, valid from DONE until the next START
// -----------------------------------------------------------------------------
module comb_sweep_ctrl
   import comb_sweep_ctrl_pkg::*;
#(
   parameter int unsigned  SETTLE = 1,
   parameter logic [15:0]  EXPECT = 16'hF888
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic        ABORT,
   input  logic        Y,
   output logic [3:0]  ABCD,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] TT,
   output logic        PASS
);

   // With no settle time each new code goes straight to sampling.
   localparam state_t STEP_STATE = (SETTLE == 0) ? S_SAMPLE : S_WAIT;

   state_t      state_q, state_d;
   logic [3:0]  abcd_q, abcd_d;
   logic [15:0] tt_q, tt_d;
   logic        busy_q, busy_d;
   logic        pass_q, pass_d;

   logic        tmr_clr;
   logic        tmr_en;
   logic        tmr_tc;

   comb_sweep_ctrl_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .clr_i  (tmr_clr),
      .en_i   (tmr_en),
      .tc_o   (tmr_tc)
   );

   always_comb begin
      state_d = state_q;
      abcd_d  = abcd_q;
      tt_d    = tt_q;
      busy_d  = busy_q;
      pass_d  = pass_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // ABORT has no meaning here, so START alone decides.
            if (START) begin
               abcd_d  = '0;
               tt_d    = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               tmr_clr = 1'b1;
               state_d = STEP_STATE;
            end
         end

         S_WAIT: begin
            if (ABORT) begin
               abcd_d  = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               tmr_en = 1'b1;
               if (tmr_tc) begin
                  state_d = S_SAMPLE;
               end
            end
         end

         S_SAMPLE: begin
            // An abort in the sample cycle discards that cycle's Y.
            if (ABORT) begin
               abcd_d  = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               tt_d[abcd_q] = Y;
               if (abcd_q == LAST_CODE) begin
                  // Compare on the completed table so PASS is valid with DONE.
                  pass_d  = (tt_d == EXPECT);
                  busy_d  = 1'b0;
                  state_d = S_FIN;
               end else begin
                  abcd_d  = abcd_q + 4'd1;
                  tmr_clr = 1'b1;
                  state_d = STEP_STATE;
               end
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         abcd_q  <= '0;
         tt_q    <= '0;
         busy_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         abcd_q  <= abcd_d;
         tt_q    <= tt_d;
         busy_q  <= busy_d;
         pass_q  <= pass_d;
      end
   end

   assign ABCD = abcd_q;
   assign BUSY = busy_q;
   assign DONE = (state_q == S_FIN);
   assign TT   = tt_q;
   assign PASS = pass_q;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comb_sweep_ctrl
// Directed bench for comb_sweep_ctrl. Instance "a" uses SETTLE=1 with the
// default EXPECT; instance "b" uses SETTLE=0 with EXPECT=16'hFF00. Each
// instance's Y is produced from its own ABCD by a selectable function.
// -----------------------------------------------------------------------------
module tb_comb_sweep_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        ABORT;
   logic        start_a, start_b;
   logic        y_a, y_b;
   logic [3:0]  abcd_a, abcd_b;
   logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
   logic [15:0] tt_a, tt_b;

   int          mode;
   int          n_checks = 0;
   int          n_fail   = 0;

   int          done_at, done_cnt, seq_err;
   logic [15:0] tt_first;

   always #5 CLK = ~CLK;

   // 0: (A&B)|(C&D)   1: D   2: A
   function automatic logic yf(input int m, input logic [3:0] c);
      case (m)
         0:       return (c[3] & c[2]) | (c[1] & c[0]);
         1:       return c[0];
         default: return c[3];
      endcase
   endfunction

   assign y_a = yf(mode, abcd_a);
   assign y_b = yf(mode, abcd_b);

   comb_sweep_ctrl #(.SETTLE(1)) u_dut_a (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (start_a),
      .ABORT (ABORT),
      .Y     (y_a),
      .ABCD  (abcd_a),
      .BUSY  (busy_a),
      .DONE  (done_a),
      .TT    (tt_a),
      .PASS  (pass_a)
   );

   comb_sweep_ctrl #(.SETTLE(0), .EXPECT(16'hFF00)) u_dut_b (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (start_b),
      .ABORT (ABORT),
      .Y     (y_b),
      .ABCD  (abcd_b),
      .BUSY  (busy_b),
      .DONE  (done_b),
      .TT    (tt_b),
      .PASS  (pass_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Pulse START (optionally with ABORT in the same cycle, optionally held for
   // 'hold' further cycles), then watch ncyc cycles. Cycle n=1 is the one right
   // after the accepting edge; code c must show in cycles c*per+1 .. c*per+per.
   task automatic sweep(input bit use_b, input bit ab, input int hold, input int ncyc,
                        output int d_at, output int d_cnt, output int s_err,
                        output logic [15:0] tt1);
      int         per;
      logic [3:0] a;
      logic       b, d;
      per   = use_b ? 1 : 2;
      d_at  = 0;
      d_cnt = 0;
      s_err = 0;
      if (use_b) start_b = 1'b1; else start_a = 1'b1;
      ABORT = ab;
      tick();
      ABORT = 1'b0;
      tt1 = use_b ? tt_b : tt_a;
      for (int n = 1; n <= ncyc; n++) begin
         if (n > hold) begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
         a = use_b ? abcd_b : abcd_a;
         b = use_b ? busy_b : busy_a;
         d = use_b ? done_b : done_a;
         if (n <= 16 * per && (a != 4'((n - 1) / per) || b != 1'b1)) s_err++;
         if (d) begin
            d_cnt++;
            if (d_at == 0) d_at = n;
         end
         tick();
      end
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      start_a = 1'b0;
      start_b = 1'b0;
      ABORT   = 1'b0;
      mode    = 0;
      RST_N   = 1'b1;
      #2 RST_N = 1'b0;
      #2;
      chk("rst_abcd", 32'(abcd_a), 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_done", 32'(done_a), 32'h0);
      chk("rst_tt",   32'(tt_a),   32'h0);
      chk("rst_pass", 32'(pass_a), 32'h0);
      tick();
      RST_N = 1'b1;
      tick();

      // AND-OR function, SETTLE=1
      mode = 0;
      sweep(1'b0, 1'b0, 0, 36, done_at, done_cnt, seq_err, tt_first);
      chk("andor_done_at", 32'(done_at),  32'd33);
      chk("andor_done_n",  32'(done_cnt), 32'd1);
      chk("andor_seq",     32'(seq_err),  32'd0);
      chk("andor_tt",      32'(tt_a),     32'hF888);
      chk("andor_pass",    32'(pass_a),   32'h1);
      chk("andor_busy",    32'(busy_a),   32'h0);

      // Y = D, mismatch against default EXPECT
      mode = 1;
      sweep(1'b0, 1'b0, 0, 36, done_at, done_cnt, seq_err, tt_first);
      chk("yd_done_n", 32'(done_cnt), 32'd1);
      chk("yd_done_at", 32'(done_at), 32'd33);
      chk("yd_tt",     32'(tt_a),     32'hAAAA);
      chk("yd_pass",   32'(pass_a),   32'h0);
      chk("yd_busy",   32'(busy_a),   32'h0);

      // Y = A, SETTLE=0: one code per cycle
      mode = 2;
      sweep(1'b1, 1'b0, 0, 20, done_at, done_cnt, seq_err, tt_first);
      chk("s0_done_at", 32'(done_at),  32'd17);
      chk("s0_done_n",  32'(done_cnt), 32'd1);
      chk("s0_seq",     32'(seq_err),  32'd0);
      chk("s0_tt",      32'(tt_b),     32'hFF00);
      chk("s0_pass",    32'(pass_b),   32'h1);

      // ABORT in the SAMPLE cycle of code 5, Y = D (Y=1 there, must not land)
      mode = 1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (11) tick();
      chk("ab_code", 32'(abcd_a), 32'h5);
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      chk("ab_abcd", 32'(abcd_a), 32'h0);
      chk("ab_busy", 32'(busy_a), 32'h0);
      chk("ab_done", 32'(done_a), 32'h0);
      chk("ab_pass", 32'(pass_a), 32'h0);
      chk("ab_tt",   32'(tt_a),   32'h000A);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_a) done_cnt++;
         tick();
      end
      chk("ab_no_done", 32'(done_cnt), 32'd0);

      // Normal sweep afterwards, START and ABORT together in IDLE
      mode = 0;
      sweep(1'b0, 1'b1, 0, 36, done_at, done_cnt, seq_err, tt_first);
      chk("ab2_done_at", 32'(done_at), 32'd33);
      chk("ab2_seq",     32'(seq_err), 32'd0);
      chk("ab2_tt",      32'(tt_a),    32'hF888);
      chk("ab2_pass",    32'(pass_a),  32'h1);

      // Asynchronous reset during code 9
      mode = 0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (18) tick();
      chk("rs_code", 32'(abcd_a), 32'h9);
      #1 RST_N = 1'b0;
      #1;
      chk("rs_abcd", 32'(abcd_a), 32'h0);
      chk("rs_busy", 32'(busy_a), 32'h0);
      chk("rs_tt",   32'(tt_a),   32'h0);
      chk("rs_done", 32'(done_a), 32'h0);
      chk("rs_pass", 32'(pass_a), 32'h0);
      tick();
      RST_N = 1'b1;
      tick();
      chk("rs_idle_busy", 32'(busy_a), 32'h0);

      // Fresh sweep with START held high while busy
      sweep(1'b0, 1'b0, 20, 36, done_at, done_cnt, seq_err, tt_first);
      chk("hold_seq",     32'(seq_err),  32'd0);
      chk("hold_done_at", 32'(done_at),  32'd33);
      chk("hold_done_n",  32'(done_cnt), 32'd1);
      chk("hold_tt",      32'(tt_a),     32'hF888);

      // Back-to-back: second START in the first IDLE cycle after FIN
      mode = 1;
      sweep(1'b0, 1'b0, 0, 33, done_at, done_cnt, seq_err, tt_first);
      chk("bb1_done_at", 32'(done_at), 32'd33);
      chk("bb1_tt",      32'(tt_a),    32'hAAAA);
      mode = 0;
      sweep(1'b0, 1'b0, 0, 36, done_at, done_cnt, seq_err, tt_first);
      chk("bb2_tt_clr",  32'(tt_first), 32'h0);
      chk("bb2_seq",     32'(seq_err),  32'd0);
      chk("bb2_done_at", 32'(done_at),  32'd33);
      chk("bb2_tt",      32'(tt_a),     32'hF888);
      chk("bb2_pass",    32'(pass_a),   32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
